// File: rtl/axi2apb_cmd_arb.sv
// rtl/axi2apb_cmd_arb.sv - AXI AW/AR round-robin arbiter into an in-order APB command FIFO
// Commands leave strictly in acceptance order; unsupported bursts are queued with an error flag.
module axi2apb_cmd_arb #(
  parameter int ADDR_BITS = 24,
  parameter int ID_BITS   = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BITS-1:0]   AWID,
  input  logic [31:0]          AWADDR,
  input  logic [3:0]           AWLEN,
  input  logic [1:0]           AWSIZE,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [ID_BITS-1:0]   ARID,
  input  logic [31:0]          ARADDR,
  input  logic [3:0]           ARLEN,
  input  logic [1:0]           ARSIZE,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic                 cmd_pop,
  output logic                 cmd_empty,
  output logic                 cmd_full,
  output logic                 cmd_read,
  output logic [ID_BITS-1:0]   cmd_id,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic                 cmd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                 ent_read [DEPTH];
  logic [ID_BITS-1:0]   ent_id   [DEPTH];
  logic [ADDR_BITS-1:0] ent_addr [DEPTH];
  logic                 ent_err  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             last_grant_read;

  logic                 grant_r;
  logic                 grant_w;
  logic                 push;
  logic                 pop;
  logic                 push_read;
  logic [ID_BITS-1:0]   push_id;
  logic [ADDR_BITS-1:0] push_addr;
  logic                 push_err;

  assign cmd_empty = (count == '0);
  assign cmd_full  = (count == CNT_W'(DEPTH));

  // On contention the channel that did not win the last push gets the slot.
  always_comb begin
    grant_r = 1'b0;
    grant_w = 1'b0;
    if (ARVALID && AWVALID) begin
      if (last_grant_read) grant_w = 1'b1;
      else                 grant_r = 1'b1;
    end else if (ARVALID) begin
      grant_r = 1'b1;
    end else if (AWVALID) begin
      grant_w = 1'b1;
    end
  end

  // Held low while reset is asserted so nothing is accepted during reset.
  assign AWREADY = grant_w & ~cmd_full & reset;
  assign ARREADY = grant_r & ~cmd_full & reset;

  assign push = (AWVALID & AWREADY) | (ARVALID & ARREADY);
  assign pop  = cmd_pop & ~cmd_empty;

  always_comb begin
    push_read = ARREADY;
    push_id   = ARREADY ? ARID : AWID;
    push_addr = ARREADY ? ARADDR[ADDR_BITS-1:0] : AWADDR[ADDR_BITS-1:0];
    push_err  = ARREADY ? ((ARLEN != 4'h0) || (ARSIZE != 2'b10))
                        : ((AWLEN != 4'h0) || (AWSIZE != 2'b10));
  end

  generate
    if (ADDR_BITS < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{AWADDR[31:ADDR_BITS], ARADDR[31:ADDR_BITS]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      last_grant_read <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        ent_read[i] <= 1'b0;
        ent_id[i]   <= '0;
        ent_addr[i] <= '0;
        ent_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        ent_read[wr_ptr] <= push_read;
        ent_id[wr_ptr]   <= push_id;
        ent_addr[wr_ptr] <= push_addr;
        ent_err[wr_ptr]  <= push_err;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        last_grant_read  <= push_read;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign cmd_read = ent_read[rd_ptr];
  assign cmd_id   = ent_id[rd_ptr];
  assign cmd_addr = ent_addr[rd_ptr];
  assign cmd_err  = ent_err[rd_ptr];

endmodule
